// File: rtl/milano_pkg.sv
// Shared types and widths for the milano core integer register file.
package milano_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : milano_pkg

// File: rtl/milano_regfile_sb.sv
// Pending-write scoreboard: one busy bit per register, set on long-latency issue,
// cleared by the returning port B write; lookups hide a clear landing this cycle.
module milano_regfile_sb
    import milano_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] look1_addr_i,
    input  logic [ADDR_W-1:0] look2_addr_i,
    input  logic [ADDR_W-1:0] look3_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              busy3_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    function automatic logic lookup(input logic [ADDR_W-1:0] a,
                                    input logic [NUM_REGS-1:0] v);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) begin
                hit = v[i];
            end
        end
        return hit;
    endfunction

    // Set is applied after clear so a new issue to a returning register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_i && (clr_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_i && (set_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy1_o = lookup(look1_addr_i, busy_q) & ~(clr_i && (clr_addr_i == look1_addr_i));
        busy2_o = lookup(look2_addr_i, busy_q) & ~(clr_i && (clr_addr_i == look2_addr_i));
        busy3_o = lookup(look3_addr_i, busy_q) & ~(clr_i && (clr_addr_i == look3_addr_i));
    end

endmodule : milano_regfile_sb

// File: rtl/milano_regfile.sv
// Integer register file x0..x31: ALU writeback on port A, long-latency results on
// port B, two combinational read ports with optional write-through bypass.
module milano_regfile
    import milano_pkg::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int NUM_REGS  = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] waddr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] waddr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              sb_set_i,
    input  logic [ADDR_W-1:0] sb_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              busy_rd_o,
    output logic              waw_err_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              waw_err_q;
    logic              waw_err_d;
    logic              wr_a_ok;
    logic              wr_b_ok;

    // Index 0 and indices beyond NUM_REGS are never architecturally writable.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              a_ok,
        input logic [ADDR_W-1:0] a_addr,
        input logic [DATA_W-1:0] a_data,
        input logic              b_ok,
        input logic [ADDR_W-1:0] b_addr,
        input logic [DATA_W-1:0] b_data
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (writable(a)) begin
            r = stored;
            if (BYPASS_EN) begin
                if (a_ok && (a_addr == a)) begin
                    r = a_data;
                end else if (b_ok && (b_addr == a)) begin
                    r = b_data;
                end
            end
        end
        return r;
    endfunction

    assign wr_a_ok   = we_a_i && writable(waddr_a_i);
    assign wr_b_ok   = we_b_i && writable(waddr_b_i);
    assign waw_err_d = wr_a_ok && wr_b_ok && (waddr_a_i == waddr_b_i);

    // Port A is applied last so it wins a same-index collision with port B.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_b_ok && (waddr_b_i == ADDR_W'(i))) begin
                regs_d[i] = wdata_b_i;
            end
            if (wr_a_ok && (waddr_a_i == ADDR_W'(i))) begin
                regs_d[i] = wdata_a_i;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            waw_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            waw_err_q <= waw_err_d;
        end
    end

    always_comb begin
        rdata1_o = rd_sel(raddr1_i, regs_q[raddr1_i], wr_a_ok, waddr_a_i, wdata_a_i,
                          wr_b_ok, waddr_b_i, wdata_b_i);
        rdata2_o = rd_sel(raddr2_i, regs_q[raddr2_i], wr_a_ok, waddr_a_i, wdata_a_i,
                          wr_b_ok, waddr_b_i, wdata_b_i);
    end

    assign waw_err_o = waw_err_q;

    milano_regfile_sb #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .set_i        (sb_set_i),
        .set_addr_i   (sb_addr_i),
        .clr_i        (we_b_i),
        .clr_addr_i   (waddr_b_i),
        .look1_addr_i (raddr1_i),
        .look2_addr_i (raddr2_i),
        .look3_addr_i (sb_addr_i),
        .busy1_o      (busy1_o),
        .busy2_o      (busy2_o),
        .busy3_o      (busy_rd_o)
    );

endmodule : milano_regfile

// File: tb/tb_milano_regfile.sv
// Directed bench for milano_regfile: bypass, no-bypass and reduced-size instances share stimulus.
module tb_milano_regfile;

    logic        clk;
    logic        rst_n;
    logic        we_a, we_b, sb_set;
    logic [4:0]  wa, wb, ra1, ra2, sba;
    logic [31:0] wda, wdb;

    logic [31:0] r1, r2, r1_nb, r2_nb, r1_nr, r2_nr;
    logic        b1, b2, brd, waw;
    logic        b1_nb, b2_nb, brd_nb, waw_nb;
    logic        b1_nr, b2_nr, brd_nr, waw_nr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we_a;
        logic [4:0]  wa;
        logic [31:0] wda;
        logic        we_b;
        logic [4:0]  wb;
        logic [31:0] wdb;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        sbs;
        logic [4:0]  sba;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r1nb;
        logic [31:0] r2nb;
        logic        b1;
        logic        b2;
        logic        brd;
        logic        waw;
    } vec_t;

    vec_t vecs[$];

    milano_regfile #(.NUM_REGS(32), .BYPASS_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(wda),
        .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(wdb),
        .raddr1_i(ra1), .rdata1_o(r1), .raddr2_i(ra2), .rdata2_o(r2),
        .sb_set_i(sb_set), .sb_addr_i(sba),
        .busy1_o(b1), .busy2_o(b2), .busy_rd_o(brd), .waw_err_o(waw)
    );

    milano_regfile #(.NUM_REGS(32), .BYPASS_EN(1'b0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n),
        .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(wda),
        .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(wdb),
        .raddr1_i(ra1), .rdata1_o(r1_nb), .raddr2_i(ra2), .rdata2_o(r2_nb),
        .sb_set_i(sb_set), .sb_addr_i(sba),
        .busy1_o(b1_nb), .busy2_o(b2_nb), .busy_rd_o(brd_nb), .waw_err_o(waw_nb)
    );

    milano_regfile #(.NUM_REGS(24), .BYPASS_EN(1'b1)) dut_nr (
        .clk_i(clk), .rst_ni(rst_n),
        .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(wda),
        .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(wdb),
        .raddr1_i(ra1), .rdata1_o(r1_nr), .raddr2_i(ra2), .rdata2_o(r2_nr),
        .sb_set_i(sb_set), .sb_addr_i(sba),
        .busy1_o(b1_nr), .busy2_o(b2_nr), .busy_rd_o(brd_nr), .waw_err_o(waw_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        we_a = 1'b0; wa = '0; wda = '0;
        we_b = 1'b0; wb = '0; wdb = '0;
        ra1 = '0; ra2 = '0; sb_set = 1'b0; sba = '0;
    endtask

    task automatic add(input logic v_we_a, input logic [4:0] v_wa, input logic [31:0] v_wda,
                       input logic v_we_b, input logic [4:0] v_wb, input logic [31:0] v_wdb,
                       input logic [4:0] v_ra1, input logic [4:0] v_ra2,
                       input logic v_sbs, input logic [4:0] v_sba,
                       input logic [31:0] v_r1, input logic [31:0] v_r2,
                       input logic [31:0] v_r1nb, input logic [31:0] v_r2nb,
                       input logic v_b1, input logic v_b2, input logic v_brd, input logic v_waw);
        vec_t v;
        v.we_a = v_we_a; v.wa = v_wa; v.wda = v_wda;
        v.we_b = v_we_b; v.wb = v_wb; v.wdb = v_wdb;
        v.ra1 = v_ra1; v.ra2 = v_ra2; v.sbs = v_sbs; v.sba = v_sba;
        v.r1 = v_r1; v.r2 = v_r2; v.r1nb = v_r1nb; v.r2nb = v_r2nb;
        v.b1 = v_b1; v.b2 = v_b2; v.brd = v_brd; v.waw = v_waw;
        vecs.push_back(v);
    endtask

    initial begin
        //   weA wa  wdataA        weB wb  wdataB        ra1 ra2 sbs sba r1            r2            r1nb          r2nb          b1 b2 brd waw
        add(1, 3,  32'h12345678, 0, 0,  32'h0,        3,  3,  0, 0,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        3,  0,  0, 0,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        0, 0, 0, 0);
        add(1, 0,  32'hFFFFFFFF, 1, 0,  32'hFFFFFFFF, 0,  0,  1, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        7,  0,  1, 7,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  7,  0, 7,  32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 1, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  7,  0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  7,  0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 1, 0, 0);
        add(0, 0,  32'h0,        1, 7,  32'hCAFE0001, 7,  7,  0, 7,  32'hCAFE0001, 32'hCAFE0001, 32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  7,  0, 7,  32'h0,        32'hCAFE0001, 32'h0,        32'hCAFE0001, 0, 0, 0, 0);
        add(0, 0,  32'h0,        1, 9,  32'h55,       9,  0,  1, 9,  32'h55,       32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        9,  9,  0, 9,  32'h55,       32'h55,       32'h55,       32'h55,       1, 1, 1, 0);
        add(1, 4,  32'hAAAA0000, 1, 4,  32'hBBBB0000, 4,  9,  0, 0,  32'hAAAA0000, 32'h55,       32'h0,        32'h55,       0, 1, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        4,  0,  0, 0,  32'hAAAA0000, 32'h0,        32'hAAAA0000, 32'h0,        0, 0, 0, 1);
        add(1, 4,  32'h0A0A0A0A, 1, 6,  32'h06060606, 4,  6,  0, 0,  32'h0A0A0A0A, 32'h06060606, 32'hAAAA0000, 32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        4,  6,  0, 0,  32'h0A0A0A0A, 32'h06060606, 32'h0A0A0A0A, 32'h06060606, 0, 0, 0, 0);
        add(1, 10, 32'h1,        1, 11, 32'h2,        11, 10, 0, 0,  32'h2,        32'h1,        32'h0,        32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        1, 9,  32'h99,       9,  0,  0, 9,  32'h99,       32'h0,        32'h55,       32'h0,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        9,  10, 0, 9,  32'h99,       32'h1,        32'h99,       32'h1,        0, 0, 0, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        12, 0,  1, 12, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
        add(1, 12, 32'h12,       0, 0,  32'h0,        12, 0,  0, 12, 32'h12,       32'h0,        32'h0,        32'h0,        1, 0, 1, 0);
        add(0, 0,  32'h0,        0, 0,  32'h0,        12, 11, 0, 0,  32'h12,       32'h2,        32'h12,       32'h2,        1, 0, 0, 0);

        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state on every index through both ports
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ra1 = 5'(i); ra2 = 5'(31 - i); sba = 5'(i);
            #1;
            chk($sformatf("rst r1[%0d]", i), r1, 32'h0);
            chk($sformatf("rst r2[%0d]", 31 - i), r2, 32'h0);
            chk($sformatf("rst busy1[%0d]", i), 32'(b1), 32'h0);
            chk($sformatf("rst busy2[%0d]", 31 - i), 32'(b2), 32'h0);
            chk($sformatf("rst busy_rd[%0d]", i), 32'(brd), 32'h0);
        end
        chk("rst waw_err", 32'(waw), 32'h0);

        // Reset asserted while x5 is being written and marked busy
        @(negedge clk);
        we_a = 1'b1; wa = 5'd5; wda = 32'hDEADBEEF; sb_set = 1'b1; sba = 5'd5; ra1 = 5'd5;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle();
        ra1 = 5'd5; sba = 5'd5;
        rst_n = 1'b1;
        #1;
        chk("midrst x5", r1, 32'h0);
        chk("midrst busy1 x5", 32'(b1), 32'h0);
        chk("midrst busy_rd x5", 32'(brd), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            we_a = vecs[i].we_a; wa = vecs[i].wa; wda = vecs[i].wda;
            we_b = vecs[i].we_b; wb = vecs[i].wb; wdb = vecs[i].wdb;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            sb_set = vecs[i].sbs; sba = vecs[i].sba;
            #1;
            chk($sformatf("v%0d rdata1", i), r1, vecs[i].r1);
            chk($sformatf("v%0d rdata2", i), r2, vecs[i].r2);
            chk($sformatf("v%0d nobyp rdata1", i), r1_nb, vecs[i].r1nb);
            chk($sformatf("v%0d nobyp rdata2", i), r2_nb, vecs[i].r2nb);
            chk($sformatf("v%0d busy1", i), 32'(b1), 32'(vecs[i].b1));
            chk($sformatf("v%0d busy2", i), 32'(b2), 32'(vecs[i].b2));
            chk($sformatf("v%0d busy_rd", i), 32'(brd), 32'(vecs[i].brd));
            chk($sformatf("v%0d waw_err", i), 32'(waw), 32'(vecs[i].waw));
            chk($sformatf("v%0d nobyp busy1", i), 32'(b1_nb), 32'(vecs[i].b1));
            chk($sformatf("v%0d nobyp busy_rd", i), 32'(brd_nb), 32'(vecs[i].brd));
            chk($sformatf("v%0d nobyp waw_err", i), 32'(waw_nb), 32'(vecs[i].waw));
            chk($sformatf("v%0d nobyp busy2", i), 32'(b2_nb), 32'(vecs[i].b2));
        end

        // Indices beyond a 24-entry file: ignored writes, zero reads, never busy
        @(negedge clk);
        idle();
        we_a = 1'b1; wa = 5'd25; wda = 32'h25252525;
        we_b = 1'b1; wb = 5'd20; wdb = 32'h20202020;
        sb_set = 1'b1; sba = 5'd27; ra1 = 5'd25; ra2 = 5'd20;
        #1;
        chk("nr byp r1 x25", r1_nr, 32'h0);
        chk("full byp r1 x25", r1, 32'h25252525);
        chk("nr byp r2 x20", r2_nr, 32'h20202020);
        @(negedge clk);
        idle();
        ra1 = 5'd25; ra2 = 5'd27; sba = 5'd27;
        #1;
        chk("nr r1 x25", r1_nr, 32'h0);
        chk("full r1 x25", r1, 32'h25252525);
        chk("nr busy1 x25", 32'(b1_nr), 32'h0);
        chk("nr busy2 x27", 32'(b2_nr), 32'h0);
        chk("full busy2 x27", 32'(b2), 32'h1);
        chk("nr busy_rd x27", 32'(brd_nr), 32'h0);
        chk("full busy_rd x27", 32'(brd), 32'h1);
        @(negedge clk);
        idle();
        we_a = 1'b1; wa = 5'd25; wda = 32'h1;
        we_b = 1'b1; wb = 5'd25; wdb = 32'h2;
        ra2 = 5'd20;
        @(negedge clk);
        idle();
        ra2 = 5'd20;
        #1;
        chk("nr waw x25", 32'(waw_nr), 32'h0);
        chk("full waw x25", 32'(waw), 32'h1);
        chk("nr r2 x20 stored", r2_nr, 32'h20202020);

        // Asynchronous reset clears storage and busy state without a clock edge
        @(negedge clk);
        idle();
        ra1 = 5'd3; ra2 = 5'd20; sba = 5'd12;
        #1;
        chk("pre-arst r1 x3", r1, 32'h12345678);
        chk("pre-arst busy_rd x12", 32'(brd), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst r1 x3", r1, 32'h0);
        chk("arst r2 x20", r2, 32'h0);
        chk("arst busy_rd x12", 32'(brd), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_milano_regfile

// File: doc/milano_regfile.md
Name: milano_regfile

Overview:
- Integer register file (x0..x31) for the milano core.
- Receives the ALU writeback triple (we/addr/wdata) on port A and long-latency results (load/multi-cycle) on port B.
- Serves two combinational read ports to decode with write-through bypass.
- Keeps a pending-write scoreboard so issue can stall on RAW/WAW hazards against in-flight long-latency ops.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (x0 hardwired zero)
BYPASS_EN, 1, 1 = same-cycle write data visible on read ports; 0 = old value read

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
we_a_i  in  1  port A (ALU) write enable
waddr_a_i  in  ADDR_W  port A write index
wdata_a_i  in  DATA_W  port A write data
we_b_i  in  1  port B (LSU/long-latency) write enable; also clears busy bit
waddr_b_i  in  ADDR_W  port B write index
wdata_b_i  in  DATA_W  port B write data
raddr1_i  in  ADDR_W  read port 1 index (rs1)
rdata1_o  out  DATA_W  read port 1 data
raddr2_i  in  ADDR_W  read port 2 index (rs2)
rdata2_o  out  DATA_W  read port 2 data
sb_set_i  in  1  issue of long-latency op: mark sb_addr_i busy
sb_addr_i  in  ADDR_W  destination index being marked busy
busy1_o  out  1  raddr1_i has a pending long-latency write
busy2_o  out  1  raddr2_i has a pending long-latency write
busy_rd_o  out  1  sb_addr_i already busy (WAW stall)
waw_err_o  out  1  registered: port A and B wrote same nonzero index in one cycle

Behaviour:
- Reset (async, rst_ni=0): all registers = 0, all busy bits = 0, waw_err_o = 0. Read outputs then reflect 0 for every index. Reset mid-operation discards pending writes and busy state immediately.
- Writes: registered at rising clk_i. Latency 1 cycle to storage.
- x0: writes ignored; reads of index 0 always return 0; busy bit 0 never sets, so busy*_o = 0 for index 0.
- Same-cycle A and B writes to different indices: both commit.
- Same-cycle A and B writes to the same nonzero index: port A data commits. waw_err_o = 1 for the following cycle only. Busy bit still cleared by B.
- Reads are combinational from storage.
- Bypass (BYPASS_EN=1): if raddr matches an active nonzero write index, return that write data. Priority: port A, then port B, then storage.
- BYPASS_EN=0: reads always return storage, i.e. the pre-write value that cycle.
- Scoreboard: one busy bit per register.
  - Set: sb_set_i=1, nonzero sb_addr_i, at clock edge.
  - Clear: we_b_i=1 on waddr_b_i at clock edge.
  - Same-cycle set and clear of the same index: set wins (new op issued), so the bit stays 1.
- busy1_o/busy2_o/busy_rd_o are combinational from the registered busy bits, masked by a same-cycle port B clear of the matching index. A result returning now does not stall; pairs with bypass.
- busy_rd_o is evaluated regardless of sb_set_i.
- Port A never touches busy bits.
- Index values ≥ NUM_REGS (only when NUM_REGS < 2^ADDR_W): writes ignored, reads return 0, busy = 0.

Decomposition:
- milano_pkg gains:
  - REG_ADDR_W = 5
  - REG_DATA_W = 32
  - REG_X0 = 5'd0
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [31:0])
- One sub-module: milano_regfile_sb (busy-bit vector with set/clear, set-wins rule, lookup outputs for three indices plus clear masking).
- Storage, write-priority logic and bypass muxes stay in the top.

Test Plan:
- Reset → read every index via both ports → all 0, busy*_o = 0. Assert rst_ni low mid-write of x5 = 0xDEADBEEF → x5 reads 0 after release.
- Port A write x3 = 0x12345678 with raddr1 = 3 same cycle → rdata1_o = 0x12345678 (BYPASS_EN=1). Next cycle storage value read = 0x12345678. With BYPASS_EN=0, same-cycle read = 0.
- Write x0 = 0xFFFFFFFF via A and B → rdata reads 0 for index 0. sb_set on x0 → busy1_o = 0.
- sb_set x7; 3 cycles later raddr2 = 7 → busy2_o = 1. we_b_i on x7 = 0xCAFE0001 with raddr2 = 7 → busy2_o = 0 and rdata2_o = 0xCAFE0001 that cycle, busy bit 0 next cycle.
- Same cycle sb_set x9 and we_b_i x9 = 0x55 → x9 = 0x55 stored, busy stays 1. Following cycle sb_addr = 9 → busy_rd_o = 1.
- Same cycle A x4 = 0xAAAA0000, B x4 = 0xBBBB0000 → x4 = 0xAAAA0000, waw_err_o = 1 for exactly one cycle. A x4 / B x6 → both stored, waw_err_o = 0.
